// File: rtl/iq_age_queue.sv
// Multi-entry issue queue: tag wakeup, oldest-ready select through an age matrix,
// plus full flush and ROB-index redirect kill.
module iq_age_queue #(
  parameter int DEPTH     = 8,
  parameter int WB_PORTS  = 2,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [PAYLOAD_W-1:0]         enq_payload,
  input  logic [PREG_W-1:0]            enq_prs1,
  input  logic [PREG_W-1:0]            enq_prs2,
  input  logic                         enq_src1_busy,
  input  logic                         enq_src2_busy,
  input  logic                         enq_robidx_flag,
  input  logic [ROB_W-1:0]             enq_robidx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]   wb_prd,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [PREG_W-1:0]            issue_prs1,
  output logic [PREG_W-1:0]            issue_prs2,
  output logic                         issue_robidx_flag,
  output logic [ROB_W-1:0]             issue_robidx,
  input  logic                         flush,
  input  logic                         redirect_valid,
  input  logic                         redirect_robidx_flag,
  input  logic [ROB_W-1:0]             redirect_robidx,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     busy1_r;
  logic [DEPTH-1:0]     busy2_r;
  logic [DEPTH-1:0]     flag_r;
  logic [DEPTH-1:0]     age_r     [DEPTH];  // age_r[e][j]=1: entry j is older than e
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];
  logic [PREG_W-1:0]    prs1_r    [DEPTH];
  logic [PREG_W-1:0]    prs2_r    [DEPTH];
  logic [ROB_W-1:0]     idx_r     [DEPTH];
  logic [CNT_W-1:0]     count_r;

  logic [DEPTH-1:0]     ready_s;
  logic [DEPTH-1:0]     sel_oh_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [DEPTH-1:0]     free_oh_s;
  logic [DEPTH-1:0]     valid_nx_s;
  logic [CNT_W-1:0]     count_nx_s;
  logic                 enq_fire_s;
  logic                 enq_write_s;
  logic                 deq_s;

  function automatic logic woken(input logic [PREG_W-1:0] tag,
                                 input logic [WB_PORTS-1:0] wv,
                                 input logic [WB_PORTS*PREG_W-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      hit = hit | (wv[p] & (wp[p*PREG_W +: PREG_W] == tag));
    end
    return hit;
  endfunction

  function automatic logic is_younger(input logic f, input logic [ROB_W-1:0] ix,
                                      input logic rf, input logic [ROB_W-1:0] rix);
    return (f != rf) ^ (ix > rix);
  endfunction

  // Ready vector, oldest-ready select and lowest free slot
  always_comb begin
    ready_s    = valid_r & ~busy1_r & ~busy2_r;
    sel_oh_s   = {DEPTH{1'b0}};
    sel_idx_s  = {IDX_W{1'b0}};
    free_idx_s = {IDX_W{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      sel_oh_s[e] = ready_s[e] & ((age_r[e] & ready_s) == {DEPTH{1'b0}});
      sel_idx_s   = sel_oh_s[e] ? IDX_W'(e) : sel_idx_s;
    end
    for (int e = DEPTH - 1; e >= 0; e--) begin
      free_idx_s = valid_r[e] ? free_idx_s : IDX_W'(e);
    end
  end

  assign free_oh_s   = {{(DEPTH-1){1'b0}}, 1'b1} << free_idx_s;
  assign enq_ready   = (count_r < CNT_W'(DEPTH));
  assign issue_valid = |ready_s;
  assign deq_s       = issue_valid & issue_ready;
  assign enq_fire_s  = enq_valid & enq_ready & ~flush;
  assign enq_write_s = enq_fire_s &
                       ~(redirect_valid & is_younger(enq_robidx_flag, enq_robidx,
                                                     redirect_robidx_flag, redirect_robidx));

  // Next-state valid vector and its population count
  always_comb begin
    valid_nx_s = {DEPTH{1'b0}};
    count_nx_s = {CNT_W{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      valid_nx_s[e] = ~flush & ((enq_write_s & free_oh_s[e]) |
                      (valid_r[e] & ~(deq_s & sel_oh_s[e]) &
                       ~(redirect_valid & is_younger(flag_r[e], idx_r[e],
                                                     redirect_robidx_flag, redirect_robidx))));
      count_nx_s = count_nx_s + CNT_W'(valid_nx_s[e]);
    end
  end

  // Control state: valid, busy, age matrix and count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= {DEPTH{1'b0}};
      busy1_r <= {DEPTH{1'b0}};
      busy2_r <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int e = 0; e < DEPTH; e++) age_r[e] <= {DEPTH{1'b0}};
    end else begin
      valid_r <= valid_nx_s;
      count_r <= count_nx_s;
      for (int e = 0; e < DEPTH; e++) begin
        if (enq_write_s && free_oh_s[e]) begin
          busy1_r[e] <= enq_src1_busy & ~woken(enq_prs1, wb_valid, wb_prd);
          busy2_r[e] <= enq_src2_busy & ~woken(enq_prs2, wb_valid, wb_prd);
          age_r[e]   <= valid_r;
        end else begin
          busy1_r[e] <= busy1_r[e] & ~woken(prs1_r[e], wb_valid, wb_prd);
          busy2_r[e] <= busy2_r[e] & ~woken(prs2_r[e], wb_valid, wb_prd);
          age_r[e]   <= enq_write_s ? (age_r[e] & ~free_oh_s) : age_r[e];
        end
      end
    end
  end

  // Entry payload and tags; only meaningful while the valid bit is set
  always_ff @(posedge clock) begin
    if (enq_write_s) begin
      payload_r[free_idx_s] <= enq_payload;
      prs1_r[free_idx_s]    <= enq_prs1;
      prs2_r[free_idx_s]    <= enq_prs2;
      flag_r[free_idx_s]    <= enq_robidx_flag;
      idx_r[free_idx_s]     <= enq_robidx;
    end
  end

  assign issue_payload     = payload_r[sel_idx_s];
  assign issue_prs1        = prs1_r[sel_idx_s];
  assign issue_prs2        = prs2_r[sel_idx_s];
  assign issue_robidx_flag = flag_r[sel_idx_s];
  assign issue_robidx      = idx_r[sel_idx_s];
  assign count             = count_r;

endmodule

// File: tb/tb_iq_age_queue.sv
// Bench for iq_age_queue: directed scenarios then random traffic, all checked
// against an in-order list model of the queue.
module tb_iq_age_queue;
  localparam int DEPTH = 8;

  logic         clock;
  logic         reset_n;
  logic         enq_valid;
  logic         enq_ready;
  logic [127:0] enq_payload;
  logic [6:0]   enq_prs1, enq_prs2;
  logic         enq_src1_busy, enq_src2_busy;
  logic         enq_robidx_flag;
  logic [5:0]   enq_robidx;
  logic [1:0]   wb_valid;
  logic [13:0]  wb_prd;
  logic         issue_valid;
  logic         issue_ready;
  logic [127:0] issue_payload;
  logic [6:0]   issue_prs1, issue_prs2;
  logic         issue_robidx_flag;
  logic [5:0]   issue_robidx;
  logic         flush;
  logic         redirect_valid;
  logic         redirect_robidx_flag;
  logic [5:0]   redirect_robidx;
  logic [3:0]   count;

  iq_age_queue dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_busy(enq_src1_busy), .enq_src2_busy(enq_src2_busy),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
    .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
    .issue_robidx_flag(issue_robidx_flag), .issue_robidx(issue_robidx),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_robidx_flag(redirect_robidx_flag), .redirect_robidx(redirect_robidx),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] pl;
    logic [6:0]   p1, p2;
    logic         b1, b2;
    logic         f;
    logic [5:0]   ix;
  } ent_t;

  ent_t mq[$];   // model: entries in age order, oldest first
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic woke(input logic [6:0] t);
    for (int p = 0; p < 2; p++)
      if (wb_valid[p] && wb_prd[p*7 +: 7] == t) return 1'b1;
    return 1'b0;
  endfunction

  // younger than redirect: forward distance on the wrapped 7-bit ROB ring is 1..64
  function automatic logic younger(input logic f, input logic [5:0] ix);
    int a, r, d;
    a = int'(f) * 64 + int'(ix);
    r = int'(redirect_robidx_flag) * 64 + int'(redirect_robidx);
    d = (a - r + 128) % 128;
    return (d >= 1) && (d <= 64);
  endfunction

  function automatic int oldest();
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].b1 && !mq[i].b2) return i;
    return -1;
  endfunction

  task automatic model_edge();
    ent_t nq[$];
    ent_t e;
    int   sel;
    sel = oldest();
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (flush) continue;
      if (i == sel && issue_ready) continue;
      if (redirect_valid && younger(e.f, e.ix)) continue;
      e.b1 = e.b1 & ~woke(e.p1);
      e.b2 = e.b2 & ~woke(e.p2);
      nq.push_back(e);
    end
    if (enq_valid && mq.size() < DEPTH && !flush &&
        !(redirect_valid && younger(enq_robidx_flag, enq_robidx))) begin
      e.pl = enq_payload; e.p1 = enq_prs1; e.p2 = enq_prs2;
      e.b1 = enq_src1_busy & ~woke(enq_prs1);
      e.b2 = enq_src2_busy & ~woke(enq_prs2);
      e.f  = enq_robidx_flag; e.ix = enq_robidx;
      nq.push_back(e);
    end
    mq = nq;
  endtask

  task automatic check();
    int sel;
    sel = oldest();
    chk("count", 128'(count), 128'(mq.size()));
    chk("enq_ready", 128'(enq_ready), 128'(mq.size() < DEPTH));
    chk("issue_valid", 128'(issue_valid), 128'(sel >= 0));
    if (sel >= 0) begin
      chk("issue_payload", issue_payload, mq[sel].pl);
      chk("issue_prs1", 128'(issue_prs1), 128'(mq[sel].p1));
      chk("issue_prs2", 128'(issue_prs2), 128'(mq[sel].p2));
      chk("issue_robidx", 128'({issue_robidx_flag, issue_robidx}), 128'({mq[sel].f, mq[sel].ix}));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check();
  endtask

  task automatic clr();
    enq_valid = 1'b0; enq_payload = 128'd0; enq_prs1 = 7'd0; enq_prs2 = 7'd0;
    enq_src1_busy = 1'b0; enq_src2_busy = 1'b0; enq_robidx_flag = 1'b0; enq_robidx = 6'd0;
    wb_valid = 2'b00; wb_prd = 14'd0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_robidx_flag = 1'b0; redirect_robidx = 6'd0;
  endtask

  task automatic set_enq(input logic [6:0] p1, input logic b1, input logic [6:0] p2,
                         input logic b2, input logic f, input logic [5:0] ix);
    enq_valid = 1'b1; enq_prs1 = p1; enq_src1_busy = b1; enq_prs2 = p2; enq_src2_busy = b2;
    enq_robidx_flag = f; enq_robidx = ix;
    enq_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    reset_n = 1'b1;
    issue_ready = 1'b0;
    clr();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check();

    // three ready uops, then drain in age order
    for (int i = 0; i < 3; i++) begin set_enq(7'd1, 1'b0, 7'd2, 1'b0, 1'b0, 6'(i)); tick(); end
    clr(); issue_ready = 1'b1;
    repeat (4) tick();

    // A waits on tag 5, B is ready; wakeup on port 1
    set_enq(7'd5, 1'b1, 7'd6, 1'b0, 1'b0, 6'd3); tick();
    set_enq(7'd7, 1'b0, 7'd8, 1'b0, 1'b0, 6'd4); tick();
    clr(); tick();
    wb_valid = 2'b10; wb_prd = {7'd5, 7'd0}; tick();
    clr(); repeat (2) tick();

    // enqueue and wakeup of the same tag in one cycle
    set_enq(7'd3, 1'b0, 7'd9, 1'b1, 1'b0, 6'd5);
    wb_valid = 2'b01; wb_prd = {7'd0, 7'd9}; tick();
    clr();
    chk("same_cycle_wake", 128'(issue_valid), 128'(1));
    tick();

    // fill, ignored enqueue while full, free one slot, refill
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin set_enq(7'd1, 1'b0, 7'd1, 1'b0, 1'b0, 6'(10 + i)); tick(); end
    chk("full_not_ready", 128'(enq_ready), 128'(0));
    set_enq(7'd1, 1'b0, 7'd1, 1'b0, 1'b0, 6'd30); tick();
    clr(); issue_ready = 1'b1; tick();
    issue_ready = 1'b0;
    set_enq(7'd1, 1'b0, 7'd1, 1'b0, 1'b0, 6'd31); tick();
    clr(); issue_ready = 1'b1;
    repeat (DEPTH + 1) tick();

    // selective redirect
    issue_ready = 1'b0;
    set_enq(7'd100, 1'b1, 7'd0, 1'b0, 1'b0, 6'd60); tick();
    set_enq(7'd100, 1'b1, 7'd0, 1'b0, 1'b0, 6'd62); tick();
    set_enq(7'd100, 1'b1, 7'd0, 1'b0, 1'b1, 6'd1);  tick();
    set_enq(7'd100, 1'b1, 7'd0, 1'b0, 1'b1, 6'd3);  tick();
    clr(); redirect_valid = 1'b1; redirect_robidx_flag = 1'b0; redirect_robidx = 6'd62; tick();
    clr();
    chk("redirect_count", 128'(count), 128'(2));

    // flush with 4 entries and a concurrent enqueue
    set_enq(7'd100, 1'b1, 7'd0, 1'b0, 1'b0, 6'd63); tick();
    set_enq(7'd101, 1'b1, 7'd0, 1'b0, 1'b1, 6'd0);  tick();
    set_enq(7'd1, 1'b0, 7'd1, 1'b0, 1'b1, 6'd2); flush = 1'b1; tick();
    clr();
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_issue_valid", 128'(issue_valid), 128'(0));

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin set_enq(7'd1, 1'b0, 7'd1, 1'b0, 1'b0, 6'(i)); tick(); end
    clr();
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("async_rst_enq_ready", 128'(enq_ready), 128'(1));
    mq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    check();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      clr();
      if ($urandom_range(9) < 7)
        set_enq(7'($urandom_range(15)), 1'($urandom_range(1)), 7'($urandom_range(15)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 6'($urandom_range(63)));
      wb_valid = 2'($urandom_range(3));
      wb_prd   = {7'($urandom_range(15)), 7'($urandom_range(15))};
      issue_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(99) < 2);
      redirect_valid = ($urandom_range(99) < 5);
      redirect_robidx_flag = 1'($urandom_range(1));
      redirect_robidx = 6'($urandom_range(63));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
